// File: rtl/mips_pkg.sv
// Shared opcode constants, instruction field positions and the fetch state encoding
// for the unpipelined MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory port. The fetch unit is the master and the memory is the slave.
// Handshake: imem_req stays high with imem_addr stable until the memory answers with a
// one-cycle imem_ack carrying imem_rdata; req may drop early only on flush, timeout or reset.
interface ifetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_decode.sv
// Combinational extraction of the jump/branch fields the PC logic needs; all outputs
// are forced to zero while the instruction register holds nothing valid.
module ifetch_decode
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [31:0]       instr,
   input  logic              valid,
   output logic              jump,
   output logic              branch,
   output logic [25:0]       jump_field,
   output logic [ADDR_W-1:0] branch_off
);
   logic [5:0] opcode;

   assign opcode     = instr[OPC_HI:OPC_LO];
   assign jump       = valid && (opcode == OP_J);
   assign branch     = valid && (opcode == OP_BEQ);
   assign jump_field = valid ? instr[25:0] : 26'd0;
   // Branch offset is a signed word offset; the PC logic adds it to pc+1.
   assign branch_off = valid ? {{(ADDR_W-16){instr[15]}}, instr[15:0]} : '0;
endmodule

// File: rtl/ifetch_unit.sv
// Fetches one instruction word per PC from variable-latency memory, holds it for decode
// and stalls the PC logic until the decode stage consumes it.
module ifetch_unit
   import mips_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fetch_en,
   input  logic [ADDR_W-1:0]   pc,
   input  logic                flush,
   input  logic                consume,
   ifetch_unit_if.master       imem,
   output logic [DATA_W-1:0]   instr,
   output logic                instr_valid,
   output logic                stall,
   output logic                jump,
   output logic                branch,
   output logic [25:0]         jump_field,
   output logic [ADDR_W-1:0]   branch_off,
   output logic                fetch_err,
   output fetch_state_t        state_dbg
);
   localparam int CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

   fetch_state_t      state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]  wait_cnt_inc;

   assign wait_cnt_inc = wait_cnt + 1'b1;
   assign stall        = !((state == HOLD) && consume);
   assign state_dbg    = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         imem.imem_req  <= 1'b0;
         imem.imem_addr <= '0;
         instr          <= '0;
         instr_valid    <= 1'b0;
         fetch_err      <= 1'b0;
         wait_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!flush && fetch_en && !fetch_err) begin
                  state          <= REQ;
                  imem.imem_req  <= 1'b1;
                  imem.imem_addr <= pc;
                  wait_cnt       <= '0;
               end
            end
            REQ: begin
               // Flush beats a same-cycle ack: the returned word belongs to a dead path.
               if (flush) begin
                  state         <= IDLE;
                  imem.imem_req <= 1'b0;
               end else if (imem.imem_ack) begin
                  state         <= HOLD;
                  imem.imem_req <= 1'b0;
                  instr         <= imem.imem_rdata;
                  instr_valid   <= 1'b1;
               end else if (TIMEOUT_CYC != 0) begin
                  wait_cnt <= wait_cnt_inc;
                  if (wait_cnt_inc == TO_VAL) begin
                     state         <= ERR;
                     imem.imem_req <= 1'b0;
                     fetch_err     <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (flush) begin
                  state       <= IDLE;
                  instr_valid <= 1'b0;
               end else if (consume) begin
                  instr_valid <= 1'b0;
                  if (fetch_en) begin
                     state          <= REQ;
                     imem.imem_req  <= 1'b1;
                     imem.imem_addr <= pc;
                     wait_cnt       <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               // ERR is absorbing; only reset leaves it.
               state         <= ERR;
               imem.imem_req <= 1'b0;
               fetch_err     <= 1'b1;
            end
         endcase
      end
   end

   ifetch_decode #(.ADDR_W(ADDR_W)) u_decode (
      .instr      (instr),
      .valid      (instr_valid),
      .jump       (jump),
      .branch     (branch),
      .jump_field (jump_field),
      .branch_off (branch_off)
   );
endmodule
